// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: one 1-bit ALU slice evaluated per clock, LSB first.
// Supports AND, OR, ADD, SUB and SLT; any other op code runs the full WIDTH
// cycles and then reports illegal with a zero result.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]     op_r;
    logic [IW-1:0]  idx;
    logic           carry;

    logic a_i;
    logic b_eff;
    logic s_sum;
    logic s_cout;
    logic s_res;
    logic legal;
    logic arith;
    logic is_slt;

    // One-bit ALU slice for the current bit index plus op classification
    always_comb begin
        a_i    = a_r[idx];
        b_eff  = b_r[idx] ^ op_r[2];
        s_sum  = a_i ^ b_eff ^ carry;
        s_cout = (a_i & b_eff) | (a_i & carry) | (b_eff & carry);
        case (op_r[1:0])
            2'b00:   s_res = a_i & b_eff;
            2'b01:   s_res = a_i | b_eff;
            2'b10:   s_res = s_sum;
            default: s_res = 1'b0;        // less input tied low
        endcase
        legal  = (op_r == 3'b000) || (op_r == 3'b001) || (op_r == 3'b010) ||
                 (op_r == 3'b110) || (op_r == 3'b111);
        arith  = legal & op_r[1];
        is_slt = (op_r == 3'b111);
    end

    assign zero = (result == '0);

    // Control FSM with registered outputs; one result bit written per RUN cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op;
                        idx   <= '0;
                        carry <= op[2];
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[idx] <= legal ? s_res : 1'b0;
                    carry       <= s_cout;
                    idx         <= idx + 1'b1;
                    if (idx == LAST) begin
                        c_out    <= arith & s_cout;
                        overflow <= arith & (carry ^ s_cout);
                        illegal  <= ~legal;
                        done     <= 1'b1;
                        state    <= DONE;
                        // SLT replaces the whole result; this later assignment wins over the bit write above
                        if (is_slt) begin
                            result <= WIDTH'(s_sum ^ carry ^ s_cout);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Testbench for alu_serial_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;
    logic         zero;
    logic         illegal;

    int checks   = 0;
    int failures = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Reference: returns {illegal, overflow, c_out, result}
    function automatic logic [W+2:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v, il;
        r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
        case (o)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[W-1:0]; c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'b110, 3'b111: begin
                s = {1'b0, x} + {1'b0, ~y} + 1;
                r = s[W-1:0]; c = s[W];
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
                if (o == 3'b111) r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            end
            default: il = 1'b1;
        endcase
        return {il, v, c, r};
    endfunction

    task automatic check_outputs(input string name, input logic [W+2:0] exp);
        checks++;
        if ({illegal, overflow, c_out, result} !== exp || zero !== (exp[W-1:0] == '0)) begin
            failures++;
            $display("FAIL %s: got ill=%0b ovf=%0b c=%0b res=%h zero=%0b, expected ill=%0b ovf=%0b c=%0b res=%h zero=%0b",
                     name, illegal, overflow, c_out, result, zero,
                     exp[W+2], exp[W+1], exp[W], exp[W-1:0], (exp[W-1:0] == '0));
        end
    endtask

    // Runs one operation; optionally scrambles inputs / holds start while busy
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit scramble, input bit hold_start, input string name);
        logic [W+2:0] exp;
        int cyc;
        exp = model(o, av, bv);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        cyc = 0;
        while (cyc < 3 * W) begin
            if (scramble) begin a = W'($urandom); b = W'($urandom); op = 3'($urandom); end
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        checks++;
        if (!done || cyc != W) begin
            failures++;
            $display("FAIL %s latency: done=%0b after %0d cycles, expected done=1 after %0d", name, done, cyc, W);
        end
        check_outputs(name, exp);
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: done=%0b busy=%0b, expected 0 0", name, done, busy);
        end
        repeat (2) begin
            a = W'($urandom); b = W'($urandom); op = 3'($urandom);
            @(posedge clk); #1;
        end
        check_outputs({name, " hold"}, exp);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op = 3'b010; a = 8'h12; b = 8'h34;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset ctrl: busy=%0b done=%0b, expected 0 0", busy, done);
        end
        check_outputs("reset", {3'b000, {W{1'b0}}});
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        run_op(3'b010, 8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
        run_op(3'b110, 8'h05, 8'h05, 1'b0, 1'b0, "sub_eq");
        run_op(3'b111, 8'h80, 8'h01, 1'b0, 1'b0, "slt_neg");
        run_op(3'b111, 8'h01, 8'h80, 1'b0, 1'b0, "slt_pos");
        run_op(3'b000, 8'hF0, 8'h3C, 1'b0, 1'b0, "and");
        run_op(3'b001, 8'hF0, 8'h3C, 1'b0, 1'b0, "or");
        run_op(3'b010, 8'hFF, 8'h01, 1'b0, 1'b0, "add_wrap");
        run_op(3'b101, 8'hAA, 8'h55, 1'b0, 1'b0, "illegal_101");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(3'($urandom), W'($urandom), W'($urandom), 1'b1, 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        int first;
        dones = 0; first = -1;
        @(negedge clk);
        op = 3'b010; a = 8'h10; b = 8'h20; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk); #1;
            if (done) begin dones++; if (first < 0) first = k; end
        end
        checks++;
        if (dones != 1 || first != W) begin
            failures++;
            $display("FAIL b2b done: count=%0d at cycle %0d, expected 1 at %0d", dones, first, W);
        end
        check_outputs("b2b", model(3'b010, 8'h10, 8'h20));
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b idle gap: busy=%0b, expected 0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b restart: busy=%0b, expected 1", busy);
        end
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        @(negedge clk);
        op = 3'b010; a = 8'h33; b = 8'h44; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort ctrl: busy=%0b done=%0b, expected 0 0", busy, done);
        end
        check_outputs("abort", {3'b000, {W{1'b0}}});
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL abort no_done: count=%0d, expected 0", dones);
        end
        run_op(3'b011, 8'h5A, 8'h0F, 1'b0, 1'b0, "illegal_011");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
